// File: rtl/debug_pkg.sv
// Shared definitions for the data-memory debug dump path: default widths and FSM encoding.
// The CSUM state only exists when DATAMEM_DUMP_CHECKSUM_EN is defined.
package debug_pkg;

    localparam int DEF_NB_REG     = 32;
    localparam int DEF_NB_ADDR    = 16;
    localparam int DEF_NB_BYTE    = 8;
    localparam int DEF_N_ADDR     = 2048;
    localparam int BYTES_PER_WORD = DEF_NB_REG / DEF_NB_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
`ifdef DATAMEM_DUMP_CHECKSUM_EN
        ST_CSUM  = 3'd4,
`endif
        ST_DONE  = 3'd5
    } dump_state_t;

endpackage

// File: rtl/word_to_byte_tx.sv
// Serializes one captured word MSB-byte-first over a valid/ready byte stream.
// A single-byte load sends only the top byte (used for the trailing checksum).
module word_to_byte_tx #(
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               single_i,
    input  logic [NB_REG-1:0]  word_i,
    input  logic               ready_i,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_valid_o,
    output logic               last_acc_o
);

    localparam int NBYTES = NB_REG / NB_BYTE;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [NB_REG-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic              single_q;
    logic              byte_acc;

    assign byte_acc   = valid_q && ready_i;
    assign last_acc_o = byte_acc && (single_q || (idx_q == LAST_IDX));
    assign tx_valid_o = valid_q;
    // The outgoing byte is always the top slice; accepted bytes are shifted out.
    assign tx_data_o  = word_q[NB_REG-1 -: NB_BYTE];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            single_q <= 1'b0;
        end else if (load_i) begin
            word_q   <= word_i;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            single_q <= single_i;
        end else if (byte_acc) begin
            word_q <= word_q << NB_BYTE;
            idx_q  <= idx_q + 1'b1;
            if (last_acc_o) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/datamem_dump_ctrl.sv
// Dumps a contiguous range of data-memory words through the debug read port to the UART TX.
// Define DATAMEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module datamem_dump_ctrl
    import debug_pkg::*;
#(
    parameter int NB_REG  = DEF_NB_REG,
    parameter int NB_ADDR = DEF_NB_ADDR,
    parameter int NB_BYTE = DEF_NB_BYTE,
    parameter int N_ADDR  = DEF_N_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_base_addr,
    input  logic [NB_ADDR-1:0] i_count,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_ADDR-1:0] o_debug_datamem_addr,
    output logic               o_debug_datamem_re,
    input  logic [NB_REG-1:0]  i_debug_datamem_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready
);

    dump_state_t        state_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_ADDR-1:0] rem_q;
    logic [NB_ADDR-1:0] addr_inc_d;
    logic               load_d;
    logic               single_d;
    logic [NB_REG-1:0]  load_word_d;
    logic               last_acc;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q;
    logic [NB_BYTE-1:0] csum_d;
`endif

    assign o_busy               = (state_q != ST_IDLE);
    assign o_done               = (state_q == ST_DONE);
    assign o_debug_datamem_re   = (state_q == ST_READ);
    assign o_debug_datamem_addr = addr_q;

    assign addr_inc_d = (addr_q == NB_ADDR'(N_ADDR - 1)) ? '0 : addr_q + 1'b1;

`ifdef DATAMEM_DUMP_CHECKSUM_EN
    assign csum_d = (o_tx_valid && i_tx_ready) ? (csum_q ^ o_tx_data) : csum_q;
`endif

    // The checksum reuses the serializer as a one-byte word, loaded as the last data byte leaves.
    always_comb begin
        load_d      = 1'b0;
        single_d    = 1'b0;
        load_word_d = i_debug_datamem_data;
        if (state_q == ST_LATCH) begin
            load_d = 1'b1;
        end
`ifdef DATAMEM_DUMP_CHECKSUM_EN
        else if ((state_q == ST_SEND) && last_acc && (rem_q == '0)) begin
            load_d      = 1'b1;
            single_d    = 1'b1;
            load_word_d = NB_REG'(csum_d) << (NB_REG - NB_BYTE);
        end
`endif
    end

    word_to_byte_tx #(
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_tx (
        .clk_i      (i_clock),
        .rst_ni     (i_reset),
        .load_i     (load_d),
        .single_i   (single_d),
        .word_i     (load_word_d),
        .ready_i    (i_tx_ready),
        .tx_data_o  (o_tx_data),
        .tx_valid_o (o_tx_valid),
        .last_acc_o (last_acc)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q  <= NB_ADDR'(i_base_addr % N_ADDR);
                        rem_q   <= i_count;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        state_q <= (i_count == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    rem_q   <= rem_q - 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                    csum_q <= csum_d;
`endif
                    if (last_acc) begin
                        if (rem_q != '0) begin
                            addr_q  <= addr_inc_d;
                            state_q <= ST_READ;
                        end else begin
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            state_q <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (last_acc) begin
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
